// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for the register file write port.
// Supports a bounded lock/burst and registers the winning write one cycle after acceptance.
module regfile_write_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SIZE      = 5,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid_i,
  input  logic             req0_lock_i,
  input  logic [SIZE-1:0]  req0_addr_i,
  input  logic [WIDTH-1:0] req0_data_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic             req1_lock_i,
  input  logic [SIZE-1:0]  req1_addr_i,
  input  logic [WIDTH-1:0] req1_data_i,
  output logic             req1_ready_o,
  output logic             reg_write_o,
  output logic [SIZE-1:0]  write_register_o,
  output logic [WIDTH-1:0] write_data_o,
  output logic             zero_drop_o
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {OWN_NONE, OWN_REQ0, OWN_REQ1} owner_e;

  owner_e          r_owner, w_owner_nxt;
  logic            r_rr, w_rr_nxt;
  logic [CW-1:0]   r_burst, w_burst_nxt;
  logic            w_gnt0, w_gnt1, w_acc;
  logic [SIZE-1:0] w_sel_addr;
  logic [WIDTH-1:0] w_sel_data;

  logic             r_reg_write, r_zero_drop;
  logic [SIZE-1:0]  r_write_register;
  logic [WIDTH-1:0] r_write_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= OWN_NONE;
      r_rr    <= 1'b0;
      r_burst <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_rr    <= w_rr_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    w_burst_nxt = '0;
    w_rr_nxt    = r_rr;
    if (w_gnt0) begin
      w_rr_nxt    = 1'b1;
      w_owner_nxt = OWN_REQ0;
      if (r_owner == OWN_REQ0)
        w_burst_nxt = (r_burst == BURST_MAX) ? r_burst : r_burst + CW'(1);
      else
        w_burst_nxt = CW'(1);
    end else if (w_gnt1) begin
      w_rr_nxt    = 1'b0;
      w_owner_nxt = OWN_REQ1;
      if (r_owner == OWN_REQ1)
        w_burst_nxt = (r_burst == BURST_MAX) ? r_burst : r_burst + CW'(1);
      else
        w_burst_nxt = CW'(1);
    end
  end

  // Lock only holds the grant for the current owner while its burst budget remains.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case ({req1_valid_i, req0_valid_i})
      2'b01: w_gnt0 = 1'b1;
      2'b10: w_gnt1 = 1'b1;
      2'b11: begin
        if (r_owner == OWN_REQ0 && req0_lock_i && r_burst < BURST_MAX)
          w_gnt0 = 1'b1;
        else if (r_owner == OWN_REQ1 && req1_lock_i && r_burst < BURST_MAX)
          w_gnt1 = 1'b1;
        else if (r_rr)
          w_gnt1 = 1'b1;
        else
          w_gnt0 = 1'b1;
      end
      default: ;
    endcase
  end

  assign req0_ready_o = w_gnt0;
  assign req1_ready_o = w_gnt1;
  assign w_acc        = w_gnt0 | w_gnt1;
  assign w_sel_addr   = w_gnt1 ? req1_addr_i : req0_addr_i;
  assign w_sel_data   = w_gnt1 ? req1_data_i : req0_data_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write      <= 1'b0;
      r_zero_drop      <= 1'b0;
      r_write_register <= '0;
      r_write_data     <= '0;
    end else begin
      r_reg_write <= w_acc && (w_sel_addr != '0);
      r_zero_drop <= w_acc && (w_sel_addr == '0);
      if (w_acc && (w_sel_addr != '0)) begin
        r_write_register <= w_sel_addr;
        r_write_data     <= w_sel_data;
      end
    end
  end

  assign reg_write_o      = r_reg_write;
  assign zero_drop_o      = r_zero_drop;
  assign write_register_o = r_write_register;
  assign write_data_o     = r_write_data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: directed steps push expected register-file writes; a negedge monitor checks them.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, l0, v1, l1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        rdy0, rdy1, reg_write_o, zero_drop_o;
  logic [4:0]  write_register_o;
  logic [31:0] write_data_o;

  regfile_write_arbiter #(.WIDTH(32), .SIZE(5), .MAX_BURST(4)) dut (
    .clk(clk), .reset(rst_n),
    .req0_valid_i(v0), .req0_lock_i(l0), .req0_addr_i(a0), .req0_data_i(d0), .req0_ready_o(rdy0),
    .req1_valid_i(v1), .req1_lock_i(l1), .req1_addr_i(a1), .req1_data_i(d1), .req1_ready_o(rdy1),
    .reg_write_o(reg_write_o), .write_register_o(write_register_o),
    .write_data_o(write_data_o), .zero_drop_o(zero_drop_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        zd;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;
  logic [31:0] mdl_rf[32];
  logic [31:0] dut_rf[32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // One cycle of stimulus: drive, check readies against the hand-computed grant, push expected write.
  task automatic step(input logic sv0, input logic sl0, input logic sv1, input logic sl1, input int expg);
    exp_t x;
    v0 = sv0; l0 = sl0; v1 = sv1; l1 = sl1;
    #2;
    chk("ready0", 64'(rdy0), 64'(expg == 0));
    chk("ready1", 64'(rdy1), 64'(expg == 1));
    if (expg >= 0) begin
      x.due = cyc + 1;
      x.zd  = (expg == 0) ? (a0 == 5'd0) : (a1 == 5'd0);
      if (!x.zd) begin
        exp_wa = (expg == 0) ? a0 : a1;
        exp_wd = (expg == 0) ? d0 : d1;
      end
      x.wa = exp_wa;
      x.wd = exp_wd;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    if (expg == 0) begin a0 = 5'((a0 % 31) + 1); d0 = d0 + 32'h0000_0101; end
    if (expg == 1) begin a1 = 5'((a1 % 31) + 1); d1 = d1 + 32'h0001_0001; end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("ready_excl", 64'(rdy0 & rdy1), 64'(0));
      chk("ready_no_valid", 64'((rdy0 & ~v0) | (rdy1 & ~v1)), 64'(0));
      while (q.size() > 0 && q[0].due < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_write: got=none want=addr %0d data %0h", q[0].wa, q[0].wd);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("reg_write", 64'(reg_write_o), 64'(!e.zd));
        chk("zero_drop", 64'(zero_drop_o), 64'(e.zd));
        chk("write_register", 64'(write_register_o), 64'(e.wa));
        chk("write_data", 64'(write_data_o), 64'(e.wd));
        if (!e.zd) mdl_rf[e.wa] = e.wd;
      end else begin
        chk("no_spurious_out", 64'(reg_write_o | zero_drop_o), 64'(0));
      end
      if (reg_write_o) dut_rf[write_register_o] = write_data_o;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin mdl_rf[i] = '0; dut_rf[i] = '0; end
    rst_n = 1'b0;
    v0 = 0; l0 = 0; v1 = 0; l1 = 0;
    a0 = 5'd5; d0 = 32'hDEAD_BEEF; a1 = 5'd8; d1 = 32'h1111_1111;
    exp_wa = '0; exp_wd = '0;
    #12;
    chk("rst_reg_write", 64'(reg_write_o), 64'(0));
    chk("rst_write_register", 64'(write_register_o), 64'(0));
    chk("rst_write_data", 64'(write_data_o), 64'(0));
    chk("rst_zero_drop", 64'(zero_drop_o), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single requesters
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, -1);

    // plain round-robin under contention
    a0 = 5'd1; d0 = 32'hA000_0000; a1 = 5'd2; d1 = 32'hB000_0000;
    repeat (2) begin step(1, 0, 1, 0, 0); step(1, 0, 1, 0, 1); end
    step(0, 0, 0, 0, -1);

    // req1 locks: first grant via single-valid, then bursts of four
    step(0, 0, 1, 1, 1);
    repeat (3) step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 0);
    repeat (4) step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 0);

    // lock without contention never stops, then saturated burst yields to rr
    repeat (6) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1);
    step(0, 0, 0, 0, -1);

    // write to r0 is dropped, previous address/data hold
    a0 = 5'd0; d0 = 32'h0000_1234;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, -1);

    // same register back to back: last accepted write wins
    a0 = 5'd9; d0 = 32'hCAFE_0000; a1 = 5'd9; d1 = 32'hBEEF_0000;
    step(1, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, -1);

    // asynchronous reset while a write is on the port
    a0 = 5'd12; d0 = 32'h55AA_55AA;
    step(1, 0, 0, 0, 0);
    v0 = 0;
    chk("pre_reset_reg_write", 64'(reg_write_o), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_reg_write", 64'(reg_write_o), 64'(0));
    chk("async_rst_write_data", 64'(write_data_o), 64'(0));
    chk("async_rst_write_register", 64'(write_register_o), 64'(0));
    exp_wa = '0; exp_wd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    a0 = 5'd20; d0 = 32'h2020_2020; a1 = 5'd21; d1 = 32'h2121_2121;
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 1);
    step(0, 0, 0, 0, -1);
    step(0, 0, 0, 0, -1);

    chk("queue_drained", 64'(q.size()), 64'(0));
    for (int i = 1; i < 32; i++) chk($sformatf("rf[%0d]", i), 64'(dut_rf[i]), 64'(mdl_rf[i]));
    chk("rf9_last_wins", 64'(dut_rf[9]), 64'(32'hCAFE_0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
